fft_bin_writer: RTL

Producer side of the spectrum bin array consumed by graphics_controller. It accepts one complex FFT output per handshake in bin order and converts it to an unsigned magnitude. The magnitude is written into the back bank of a double-buffered N-entry array. When a full frame is written, and only when the display permits it, the block swaps banks, presents the new frame on `freq_samples`, and pulses `fft_done`.

---
 rtl/spectrum_pkg.sv | 20 ++
 rtl/fft_bin_writer_if.sv | 27 ++
 rtl/fft_bin_writer_cplx_mag.sv | 64 ++++++
 rtl/fft_bin_writer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | spectrum_pkg : shared widths, magnitude type and writer states   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package spectrum_pkg;

   localparam int DEFAULT_WIDTH = 12;
   localparam int DEFAULT_N     = 256;

   typedef logic [DEFAULT_WIDTH:0] mag_t;

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      DRAIN     = 2'd1,
      WAIT_SWAP = 2'd2
   } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_bin_writer_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fft_bin_writer_if : complex-bin valid/ready stream               |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
interface fft_bin_writer_if #(
   parameter int WIDTH = spectrum_pkg::DEFAULT_WIDTH
) ();

   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH:0]   in_re;
   logic signed [WIDTH:0]   in_im;
   logic                    in_last;

   modport master (
      output in_valid, in_re, in_im, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_re, in_im, in_last,
      output in_ready
   );

endinterface
`default_nettype wire

// File: rtl/fft_bin_writer_cplx_mag.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | cplx_mag : registered |re|,|im| then alpha-max-beta-min (3/8)    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module cplx_mag
   import spectrum_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int IDXW  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   input  logic signed [WIDTH:0] re_i,
   input  logic signed [WIDTH:0] im_i,
   input  logic [IDXW-1:0]       idx_i,
   output logic                  valid_o,
   output logic [IDXW-1:0]       idx_o,
   output logic [WIDTH:0]        mag_o
);

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   // Two's-complement magnitude kept at WIDTH+1 bits so -2^WIDTH maps to 2^WIDTH.
   function automatic logic [WIDTH:0] abs_u(input logic signed [WIDTH:0] x);
      logic [WIDTH:0] u;
      u = x;
      return u[WIDTH] ? (~u + ONE) : u;
   endfunction

   logic                 valid_q;
   logic [WIDTH:0]       are_q;
   logic [WIDTH:0]       aim_q;
   logic [IDXW-1:0]      idx_q;
   logic [WIDTH:0]       max_v;
   logic [WIDTH:0]       min_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         are_q   <= '0;
         aim_q   <= '0;
         idx_q   <= '0;
      end else begin
         valid_q <= valid_i;
         are_q   <= abs_u(re_i);
         aim_q   <= abs_u(im_i);
         idx_q   <= idx_i;
      end
   end

   always_comb begin
      max_v = (are_q >= aim_q) ? are_q : aim_q;
      min_v = (are_q >= aim_q) ? aim_q : are_q;
   end

   // Bounded by 11/8 * 2^WIDTH, so the sum never overflows WIDTH+1 bits.
   assign mag_o   = max_v + (min_v >> 2) + (min_v >> 3);
   assign valid_o = valid_q;
   assign idx_o   = idx_q;

endmodule
`default_nettype wire

// File: rtl/fft_bin_writer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fft_bin_writer : FFT bins -> magnitudes into a double-buffered   |
// | array, swapped to the display only when swap_en allows. Rev 1.0  |
// +-----------------------------------------------------------------+
module fft_bin_writer
   import spectrum_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N     = DEFAULT_N
) (
   input  logic                clk_25MHz,
   input  logic                rst_n,
   fft_bin_writer_if.slave     in_if,
   input  logic                swap_en,
   output logic [WIDTH:0]      freq_samples [N],
   output logic                fft_done,
   output logic                frame_err
);

   localparam int              IDXW     = $clog2(N);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   wr_state_t        state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             drain_q, drain_d;
   logic             bank_sel_q, bank_sel_d;
   logic             fft_done_q, fft_done_d;
   logic             frame_err_q, frame_err_d;
   logic             run_q;
   logic             accept;

   logic             mag_valid;
   logic [IDXW-1:0]  mag_idx;
   logic [WIDTH:0]   mag;

   logic [WIDTH:0]   bank0_q [N];
   logic [WIDTH:0]   bank1_q [N];

   // run_q holds in_ready low throughout reset and releases it one edge later.
   assign in_if.in_ready = run_q && (state_q == FILL);
   assign accept         = in_if.in_valid && in_if.in_ready;

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         idx_q       <= '0;
         drain_q     <= 1'b0;
         bank_sel_q  <= 1'b0;
         fft_done_q  <= 1'b0;
         frame_err_q <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         drain_q     <= drain_d;
         bank_sel_q  <= bank_sel_d;
         fft_done_q  <= fft_done_d;
         frame_err_q <= frame_err_d;
         run_q       <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      drain_d     = drain_q;
      bank_sel_d  = bank_sel_q;
      fft_done_d  = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         FILL: begin
            if (accept) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DRAIN;
                  idx_d   = '0;
                  drain_d = 1'b0;
               end else if (in_if.in_last) begin
                  frame_err_d = 1'b1;
                  idx_d       = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            // Two cycles guarantee the final bin has landed before any swap.
            if (drain_q) state_d = WAIT_SWAP;
            else         drain_d = 1'b1;
         end
         WAIT_SWAP: begin
            if (swap_en) begin
               bank_sel_d = ~bank_sel_q;
               state_d    = FILL;
               fft_done_d = 1'b1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   cplx_mag #(
      .WIDTH (WIDTH),
      .IDXW  (IDXW)
   ) u_mag (
      .clk     (clk_25MHz),
      .rst_n   (rst_n),
      .valid_i (accept),
      .re_i    (in_if.in_re),
      .im_i    (in_if.in_im),
      .idx_i   (idx_q),
      .valid_o (mag_valid),
      .idx_o   (mag_idx),
      .mag_o   (mag)
   );

   // Writes only ever target the back bank (the one not selected for display).
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            bank0_q[k] <= '0;
            bank1_q[k] <= '0;
         end
      end else if (mag_valid) begin
         if (bank_sel_q) bank0_q[mag_idx] <= mag;
         else            bank1_q[mag_idx] <= mag;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_front
      assign freq_samples[k] = bank_sel_q ? bank1_q[k] : bank0_q[k];
   end

   assign fft_done  = fft_done_q;
   assign frame_err = frame_err_q;

endmodule
`default_nettype wire
